// File: rtl/fifo2uart_sched.sv
// fifo2uart_sched: pulls announced packets out of the shared byte FIFO and hands them to uart_tx.
// Define FIFO2UART_CSUM_EN to append an XOR checksum byte after each packet's data.
module fifo2uart_sched #(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1000,
    parameter int LEN_W   = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             pkt_done,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_dout,
    output logic [7:0]       uart_txd,
    output logic             uart_txdv,
    input  logic             uart_txdr,
    output logic             busy,
    output logic             tx_done,
    output logic             err
);

    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

`ifdef FIFO2UART_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND} state_t;
`endif

    state_t           state_q, state_d;
    logic             slot_vld_q, slot_vld_d;
    logic [LEN_W-1:0] slot_len_q, slot_len_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       lat_q, lat_d;
    logic [7:0]       txd_q, txd_d;
    logic             txdv_q, txdv_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pkt_ok;
`ifdef FIFO2UART_CSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign uart_txd  = txd_q;
    assign uart_txdv = txdv_q;
    assign tx_done   = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        slot_vld_d = slot_vld_q;
        slot_len_d = slot_len_q;
        remain_d   = remain_q;
        tmo_d      = tmo_q;
        lat_d      = lat_q;
        txd_d      = txd_q;
        txdv_d     = txdv_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fifo_rd_en = 1'b0;
`ifdef FIFO2UART_CSUM_EN
        csum_d     = csum_q;
`endif
        pkt_ok     = pkt_done && (pkt_len != '0);

        // The slot is drained before a fresh strobe is taken; a strobe seen meanwhile refills it.
        if (state_q == S_IDLE) begin
            if (slot_vld_q) begin
                remain_d   = slot_len_q;
                slot_vld_d = pkt_ok;
                if (pkt_ok) slot_len_d = pkt_len;
                state_d    = S_FETCH;
            end else if (pkt_ok) begin
                remain_d = pkt_len;
                state_d  = S_FETCH;
            end
`ifdef FIFO2UART_CSUM_EN
            if (state_d == S_FETCH) csum_d = '0;
`endif
        end else if (pkt_ok) begin
            if (slot_vld_q) begin
                err_d = 1'b1;
            end else begin
                slot_vld_d = 1'b1;
                slot_len_d = pkt_len;
            end
        end

        case (state_q)
            S_IDLE: begin
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    tmo_d      = '0;
                    lat_d      = '0;
                    state_d    = S_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    tmo_d    = '0;
                    remain_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    txd_d   = fifo_dout;
                    txdv_d  = 1'b1;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                if (txdv_q && uart_txdr) begin
                    txdv_d   = 1'b0;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
`ifdef FIFO2UART_CSUM_EN
                        csum_d  = csum_q ^ txd_q;
                        txd_d   = csum_q ^ txd_q;
                        txdv_d  = 1'b1;
                        state_d = S_CSUM;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
`ifdef FIFO2UART_CSUM_EN
                        csum_d = csum_q ^ txd_q;
`endif
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef FIFO2UART_CSUM_EN
            S_CSUM: begin
                if (txdv_q && uart_txdr) begin
                    txdv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_vld_q <= 1'b0;
            slot_len_q <= '0;
            remain_q   <= '0;
            tmo_q      <= '0;
            lat_q      <= '0;
            txd_q      <= '0;
            txdv_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef FIFO2UART_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            slot_vld_q <= slot_vld_d;
            slot_len_q <= slot_len_d;
            remain_q   <= remain_d;
            tmo_q      <= tmo_d;
            lat_q      <= lat_d;
            txd_q      <= txd_d;
            txdv_q     <= txdv_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef FIFO2UART_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo2uart_sched.sv
// Randomised and directed bench for fifo2uart_sched against a packet-level reference model
// plus a FIFO model with true read latency.
module tb_fifo2uart_sched;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 50;
    localparam int LEN_W   = 8;
`ifdef FIFO2UART_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic             sys_clk = 1'b0;
    logic             rst, pkt_done, fifo_empty, fifo_rd_en;
    logic             uart_txdv, uart_txdr, busy, tx_done, err;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       fifo_dout, uart_txd;
    logic [7:0]       pipe [RD_LAT];

    always #5 sys_clk = ~sys_clk;
    assign fifo_dout = pipe[RD_LAT-1];

    fifo2uart_sched #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .sys_clk(sys_clk), .rst(rst), .pkt_done(pkt_done), .pkt_len(pkt_len),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .uart_txd(uart_txd), .uart_txdv(uart_txdv), .uart_txdr(uart_txdr),
        .busy(busy), .tx_done(tx_done), .err(err)
    );

    int         n_chk = 0, n_fail = 0;
    logic [7:0] fq[$], exp_q[$], sent_q[$];
    bit         m_active, m_pend, m_out, m_csum_ph, exp_done_nxt, exp_err_nxt;
    bit         prev_dv, prev_acc, rnd_rdy;
    int         m_remain, m_pend_len, starve, cyc, rd_cyc, stall_n, stall_cnt;
    int         c_rd, c_acc, c_done, c_err, last_acc_cyc, last_err_cyc;
    logic [7:0] m_csum, prev_d;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_out = 0; m_csum_ph = 0; starve = 0;
        exp_done_nxt = 0; exp_err_nxt = 0; prev_dv = 0; prev_acc = 0;
        exp_q.delete();
    endtask

    task automatic start_pkt(input int len);
        m_active = 1; m_remain = len; m_csum = 8'h00; m_out = 0; m_csum_ph = 0; starve = 0;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance FIFO and ready models.
    task automatic cycle();
        bit acc, act0, pend0, awaiting, rd_s;
        rd_s = 1'b0;
        @(negedge sys_clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            act0     = m_active;
            pend0    = m_pend;
            acc      = uart_txdv && uart_txdr;
            rd_s     = fifo_rd_en;
            awaiting = m_active && !m_out && !m_csum_ph;
            check_eq("busy", busy, m_active);
            check_eq("tx_done", tx_done, exp_done_nxt);
            check_eq("err", err, exp_err_nxt);
            check_eq("rd_en", fifo_rd_en, awaiting && !fifo_empty);
            check_eq("rd_dv_overlap", fifo_rd_en && uart_txdv, 1'b0);
            if (tx_done) c_done++;
            if (err) begin c_err++; last_err_cyc = cyc; end
            exp_done_nxt = 0;
            exp_err_nxt  = 0;
            if (prev_dv && !prev_acc) begin
                check_eq("hold_dv", uart_txdv, 1'b1);
                check_eq("hold_d", uart_txd, prev_d);
            end
            if (uart_txdv && !prev_dv && m_out) check_eq("rd_to_dv", cyc - rd_cyc, RD_LAT + 1);
            if (fifo_rd_en) begin m_out = 1; rd_cyc = cyc; c_rd++; end
            if (awaiting && fifo_empty) begin
                starve++;
                if (starve == TIMEOUT) begin exp_err_nxt = 1; m_active = 0; starve = 0; end
            end else begin
                starve = 0;
            end
            if (acc) begin
                c_acc++;
                last_acc_cyc = cyc;
                sent_q.push_back(uart_txd);
                if (m_csum_ph) begin
                    check_eq("csum_byte", uart_txd, m_csum);
                    m_csum_ph = 0; m_active = 0; exp_done_nxt = 1;
                end else begin
                    check_eq("send_has_read", m_out, 1'b1);
                    if (exp_q.size() == 0) check_eq("send_data_avail", exp_q.size(), 1);
                    else check_eq("send_data", uart_txd, exp_q.pop_front());
                    m_out = 0;
                    m_csum ^= uart_txd;
                    m_remain--;
                    if (m_remain <= 0) begin
`ifdef FIFO2UART_CSUM_EN
                        m_csum_ph = 1;
`else
                        m_active = 0; exp_done_nxt = 1;
`endif
                    end
                end
            end
            if (pkt_done && pkt_len != 0) begin
                if (act0) begin
                    if (pend0) exp_err_nxt = 1;
                    else begin m_pend = 1; m_pend_len = pkt_len; end
                end else if (pend0) begin
                    start_pkt(m_pend_len);
                    m_pend_len = pkt_len;
                end else begin
                    start_pkt(pkt_len);
                end
            end else if (!act0 && pend0) begin
                start_pkt(m_pend_len);
                m_pend = 0;
            end
            prev_dv  = uart_txdv;
            prev_d   = uart_txd;
            prev_acc = acc;
        end
        @(posedge sys_clk);
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        if (rd_s && fq.size() == 0) begin
            check_eq("fifo_underrun", fq.size(), 1);
            pipe[0] = 8'($urandom);
        end else if (rd_s) begin
            pipe[0] = fq.pop_front();
            exp_q.push_back(pipe[0]);
        end else begin
            pipe[0] = 8'($urandom);
        end
        fifo_empty = (fq.size() == 0);
        if (rnd_rdy) begin
            uart_txdr = 1'($urandom_range(0, 1));
        end else begin
            stall_cnt = uart_txdv ? stall_cnt + 1 : 0;
            uart_txdr = (stall_cnt > stall_n);
        end
    endtask

    task automatic announce(input int len);
        pkt_done = 1'b1;
        pkt_len  = LEN_W'(len);
        cycle();
        pkt_done = 1'b0;
        pkt_len  = LEN_W'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_active || m_pend || busy) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check_eq("drain_idle", busy, 1'b0);
        repeat (2) cycle();
    endtask

    initial begin
        int r0, d0, e0, a0, n;
        logic [7:0] e1 [3];
        rst = 1'b1; pkt_done = 1'b0; pkt_len = '0; uart_txdr = 1'b0; fifo_empty = 1'b1;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
        rnd_rdy = 0; stall_n = 0; stall_cnt = 0; cyc = 0; rd_cyc = 0;
        c_rd = 0; c_acc = 0; c_done = 0; c_err = 0; last_acc_cyc = 0; last_err_cyc = 0;
        model_reset();
        repeat (3) cycle();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("rst_txdv", uart_txdv, 1'b0);
        check_eq("rst_txd", uart_txd, 8'h00);
        check_eq("rst_tx_done", tx_done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        rst = 1'b0;
        cycle();

        // Basic packet, ready held high, then with 20-cycle stalls per byte.
        e1[0] = 8'h11; e1[1] = 8'h22; e1[2] = 8'h33;
        for (int pass = 0; pass < 2; pass++) begin
            stall_n = (pass == 0) ? 0 : 20;
            r0 = c_rd; d0 = c_done; e0 = c_err;
            sent_q.delete();
            for (int k = 0; k < 3; k++) push(e1[k]);
            announce(3);
            drain(2000);
            check_eq("t1_reads", c_rd - r0, 3);
            check_eq("t1_sent", sent_q.size(), 3 + CS);
            for (int k = 0; k < 3; k++) check_eq("t1_byte", sent_q[k], e1[k]);
            check_eq("t1_done", c_done - d0, 1);
            check_eq("t1_err", c_err - e0, 0);
        end
        stall_n = 0;

        // Pending slot fills, third strobe dropped.
        d0 = c_done; e0 = c_err;
        sent_q.delete();
        for (int k = 0; k < 4; k++) push(8'(8'hA0 + k));
        announce(4);
        repeat (3) cycle();
        push(8'hB0); push(8'hB1);
        announce(2);
        repeat (3) cycle();
        announce(3);
        drain(2000);
        check_eq("t3_sent", sent_q.size(), 6 + 2 * CS);
        check_eq("t3_done", c_done - d0, 2);
        check_eq("t3_err", c_err - e0, 1);

        // Starvation abort.
        d0 = c_done; e0 = c_err;
        sent_q.delete();
        push(8'h5C); push(8'hC5);
        announce(4);
        drain(2000);
        check_eq("t4_sent", sent_q.size(), 2);
        check_eq("t4_done", c_done - d0, 0);
        check_eq("t4_err", c_err - e0, 1);
        check_eq("t4_err_delay", last_err_cyc - last_acc_cyc, TIMEOUT + 1);

        // Zero-length strobe is ignored.
        r0 = c_rd; d0 = c_done; e0 = c_err;
        push(8'h5A);
        announce(0);
        repeat (10) cycle();
        check_eq("t5_reads", c_rd - r0, 0);
        check_eq("t5_done", c_done - d0, 0);
        check_eq("t5_err", c_err - e0, 0);
        fq.delete();
        fifo_empty = 1'b1;

`ifdef FIFO2UART_CSUM_EN
        d0 = c_done;
        sent_q.delete();
        push(8'h0F); push(8'hF0); push(8'h55);
        announce(3);
        drain(2000);
        check_eq("csum_sent", sent_q.size(), 4);
        check_eq("csum_4th", sent_q[3], 8'hAA);
        check_eq("csum_done", c_done - d0, 1);
`endif

        // Reset in the middle of a packet.
        for (int k = 0; k < 4; k++) push(8'(8'hD0 + k));
        announce(4);
        a0 = c_acc; n = 0;
        while (c_acc == a0 && n < 200) begin cycle(); n++; end
        if (n >= 200) check_eq("t6_first_byte", c_acc - a0, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_rd_en", fifo_rd_en, 1'b0);
        check_eq("t6_txdv", uart_txdv, 1'b0);
        check_eq("t6_txd", uart_txd, 8'h00);
        check_eq("t6_tx_done", tx_done, 1'b0);
        check_eq("t6_err", err, 1'b0);
        repeat (2) cycle();
        rst = 1'b0;
        r0 = c_rd;
        repeat (10) cycle();
        check_eq("t6_no_reads", c_rd - r0, 0);
        fq.delete();
        fifo_empty = 1'b1;

        // Random traffic with random ready.
        rnd_rdy = 1;
        for (int it = 0; it < 150; it++) begin
            int len, npush;
            len   = $urandom_range(0, 5);
            npush = len;
            if (len > 0 && $urandom_range(0, 9) == 0) npush = len - 1;
            for (int k = 0; k < npush; k++) push(8'($urandom));
            announce(len);
            repeat ($urandom_range(0, 12)) cycle();
        end
        drain(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
